// File: rtl/panel_ctl.sv
// PDP-6 console front-panel controller: Avalon-MM register block driving keys and
// switches, debouncing external panel switches, and returning lamps through a snapshot shadow.
module panel_ctl #(
  parameter int NKEYS     = 16,
  parameter int NSW       = 16,
  parameter int NEXT      = 4,
  parameter int NLAMP     = 8,
  parameter int PULSE_LEN = 1000,
  parameter int DB_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            s_address,
  input  logic                  s_write,
  input  logic                  s_read,
  input  logic [31:0]           s_writedata,
  output logic [31:0]           s_readdata,
  output logic                  s_waitrequest,
  output logic                  s_irq,
  output logic [NKEYS-1:0]      keys,
  output logic [NSW-1:0]        sw,
  input  logic [NEXT-1:0]       ext,
  output logic [NEXT-1:0]       ext_db,
  input  logic [NLAMP*32-1:0]   lamps
);

  localparam logic [15:0] PULSE_VAL = 16'(PULSE_LEN);
  localparam logic [19:0] DB_VAL    = 20'(DB_CYCLES);

  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  rd_state_t        state_q, state_d;
  logic             rd_start;
  logic [31:0]      rdata_q, rdata_d, rd_val;
  logic [NSW-1:0]   sw_q, sw_d;
  logic             irq_q, irq_d;
  logic [31:0]      shadow_q [NLAMP];
  logic             snap;
  logic             wr_key_set, wr_key_clr, wr_sw_set, wr_sw_clr, wr_pulse, wr_ext, wr_snap;
  logic [NKEYS-1:0] set_req, eff_set, clr_req;
  logic [NEXT-1:0]  db_change;
  logic             unused_wdata;

  assign wr_key_set = s_write && (s_address == 6'd0);
  assign wr_key_clr = s_write && (s_address == 6'd1);
  assign wr_sw_set  = s_write && (s_address == 6'd2);
  assign wr_sw_clr  = s_write && (s_address == 6'd3);
  assign wr_pulse   = s_write && (s_address == 6'd4);
  assign wr_ext     = s_write && (s_address == 6'd5);
  assign wr_snap    = s_write && (s_address == 6'd6);

  assign set_req      = (wr_key_set || wr_pulse) ? s_writedata[NKEYS-1:0] : '0;
  assign clr_req      = wr_key_clr ? s_writedata[NKEYS-1:0] : '0;
  assign unused_wdata = ^s_writedata;

  // Rocker pairs: the odd key of a pair wins when both are requested together.
  genvar gi;
  generate
    for (gi = 0; gi < NKEYS / 2; gi++) begin : g_pair
      assign eff_set[2*gi+1] = set_req[2*gi+1];
      assign eff_set[2*gi]   = set_req[2*gi] & ~set_req[2*gi+1];
    end

    for (gi = 0; gi < NKEYS; gi++) begin : g_key
      logic        key_q, key_d;
      logic [15:0] cnt_q, cnt_d;

      always_comb begin
        key_d = key_q;
        cnt_d = cnt_q;
        if (eff_set[gi]) begin
          key_d = 1'b1;
          cnt_d = wr_pulse ? PULSE_VAL : 16'd0;
        end else if (eff_set[gi ^ 1] || clr_req[gi]) begin
          key_d = 1'b0;
          cnt_d = 16'd0;
        end else if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) key_d = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          key_q <= 1'b0;
          cnt_q <= 16'd0;
        end else begin
          key_q <= key_d;
          cnt_q <= cnt_d;
        end
      end

      assign keys[gi] = key_q;
    end

    for (gi = 0; gi < NEXT; gi++) begin : g_ext
      logic        s1_q, s2_q, prev_q, db_q, db_d;
      logic [19:0] cnt_q, cnt_d;

      // Counter saturates at DB_VAL; ext_db follows in the same edge the count is reached.
      always_comb begin
        cnt_d = cnt_q;
        if (s2_q != prev_q)      cnt_d = 20'd0;
        else if (cnt_q != DB_VAL) cnt_d = cnt_q + 20'd1;
        db_d = (cnt_d == DB_VAL) ? s2_q : db_q;
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          s1_q   <= 1'b0;
          s2_q   <= 1'b0;
          prev_q <= 1'b0;
          db_q   <= 1'b0;
          cnt_q  <= 20'd0;
        end else begin
          s1_q   <= ext[gi];
          s2_q   <= s1_q;
          prev_q <= s2_q;
          db_q   <= db_d;
          cnt_q  <= cnt_d;
        end
      end

      assign ext_db[gi]    = db_q;
      assign db_change[gi] = db_d ^ db_q;
    end
  endgenerate

  always_comb begin
    rd_val = '0;
    case (s_address)
      6'd0: rd_val[NKEYS-1:0] = keys;
      6'd2: rd_val[NSW-1:0]   = sw_q;
      6'd5: begin
        rd_val[NEXT-1:0] = ext_db;
        rd_val[31]       = irq_q;
      end
      default: ;
    endcase
    // Address 8 returns the live word 0, which is what the snapshot taken this cycle will hold.
    for (int k = 0; k < NLAMP; k++) begin
      if (s_address == 6'(8 + k)) rd_val = (k == 0) ? lamps[31:0] : shadow_q[k];
    end
  end

  always_comb begin
    state_d       = state_q;
    rd_start      = 1'b0;
    rdata_d       = rdata_q;
    case (state_q)
      RD_IDLE: if (s_read && !s_write) begin
        rd_start = 1'b1;
        state_d  = RD_DATA;
      end
      RD_DATA: state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
    if (rd_start) rdata_d = rd_val;
    s_waitrequest = rd_start;

    sw_d = sw_q;
    if (wr_sw_set) sw_d = sw_d | s_writedata[NSW-1:0];
    if (wr_sw_clr) sw_d = sw_d & ~s_writedata[NSW-1:0];

    irq_d = irq_q;
    if (wr_ext)      irq_d = 1'b0;
    if (|db_change)  irq_d = 1'b1;

    snap = wr_snap || (rd_start && (s_address == 6'd8));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RD_IDLE;
      rdata_q <= 32'd0;
      sw_q    <= '0;
      irq_q   <= 1'b0;
      for (int k = 0; k < NLAMP; k++) shadow_q[k] <= 32'd0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      sw_q    <= sw_d;
      irq_q   <= irq_d;
      if (snap) begin
        for (int k = 0; k < NLAMP; k++) shadow_q[k] <= lamps[32*k +: 32];
      end
    end
  end

  assign s_readdata = rdata_q;
  assign sw         = sw_q;
  assign s_irq      = irq_q;

endmodule

// File: tb/tb_panel_ctl.sv
// Self-checking bench for panel_ctl: register vector table, read scoreboard,
// pulse/debounce/snapshot/reset sequences.
module tb_panel_ctl;
  localparam int NKEYS = 16, NSW = 16, NEXT = 4, NLAMP = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [5:0]         s_address;
  logic               s_write, s_read;
  logic [31:0]        s_writedata, s_readdata;
  logic               s_waitrequest, s_irq;
  logic [NKEYS-1:0]   keys;
  logic [NSW-1:0]     sw;
  logic [NEXT-1:0]    ext, ext_db;
  logic [NLAMP*32-1:0] lamps;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  panel_ctl #(.NKEYS(NKEYS), .NSW(NSW), .NEXT(NEXT), .NLAMP(NLAMP),
              .PULSE_LEN(5), .DB_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .s_address(s_address), .s_write(s_write),
    .s_read(s_read), .s_writedata(s_writedata), .s_readdata(s_readdata),
    .s_waitrequest(s_waitrequest), .s_irq(s_irq), .keys(keys), .sw(sw),
    .ext(ext), .ext_db(ext_db), .lamps(lamps));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // All tasks are entered and left on a falling edge.
  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    s_address = a; s_writedata = d; s_write = 1'b1;
    #1 chk("wr_wait", 32'(s_waitrequest), 32'd0);
    @(negedge clk);
    s_write = 1'b0;
    $display("wr addr=%0d data=%h keys=%h sw=%h", a, d, keys, sw);
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp);
    int n;
    logic [31:0] e;
    exp_q.push_back(exp);
    s_address = a; s_read = 1'b1;
    #1 chk("rd_wait0", 32'(s_waitrequest), 32'd1);
    @(negedge clk);
    n = 0;
    while (s_waitrequest && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk("rd_wait1", 32'(s_waitrequest), 32'd0);
    e = exp_q.pop_front();
    chk($sformatf("rd_addr%0d", a), s_readdata, e);
    $display("rd addr=%0d data=%h", a, s_readdata);
    @(negedge clk);
    s_read = 1'b0;
  endtask

  // Pulse key2 at cycle 0, optionally write act_a with key2 bit at cycle act_c.
  task automatic pulse_seq(input int act_c, input logic [5:0] act_a, input int len);
    s_address = 6'd4; s_writedata = 32'h4; s_write = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      s_write = 1'b0;
      if (c == act_c) begin
        s_address = act_a; s_writedata = 32'h4; s_write = 1'b1;
      end
      chk($sformatf("pulse_len%0d_c%0d", len, c), 32'(keys), (c <= len) ? 32'h4 : 32'h0);
    end
    $display("pulse act_c=%0d act_a=%0d len=%0d", act_c, act_a, len);
  endtask

  typedef struct {
    bit          is_rd;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [15:0] exp_keys;
    logic [15:0] exp_sw;
  } vec_t;

  vec_t tbl [18];

  initial begin
    int n;
    tbl = '{
      '{1'b0, 6'd0,  32'h0001,     16'h0001, 16'h0000},
      '{1'b0, 6'd0,  32'h0002,     16'h0002, 16'h0000},
      '{1'b0, 6'd0,  32'h0001,     16'h0001, 16'h0000},
      '{1'b0, 6'd0,  32'h0003,     16'h0002, 16'h0000},
      '{1'b0, 6'd1,  32'h0002,     16'h0000, 16'h0000},
      '{1'b0, 6'd0,  32'h0005,     16'h0005, 16'h0000},
      '{1'b1, 6'd0,  32'h0005,     16'h0005, 16'h0000},
      '{1'b1, 6'd1,  32'h0000,     16'h0005, 16'h0000},
      '{1'b0, 6'd1,  32'h0005,     16'h0000, 16'h0000},
      '{1'b0, 6'd2,  32'hF0F0,     16'h0000, 16'hF0F0},
      '{1'b0, 6'd3,  32'h00F0,     16'h0000, 16'hF000},
      '{1'b1, 6'd2,  32'hF000,     16'h0000, 16'hF000},
      '{1'b1, 6'd3,  32'h0000,     16'h0000, 16'hF000},
      '{1'b1, 6'd7,  32'h0000,     16'h0000, 16'hF000},
      '{1'b0, 6'd40, 32'hFFFF,     16'h0000, 16'hF000},
      '{1'b1, 6'd40, 32'h0000,     16'h0000, 16'hF000},
      '{1'b0, 6'd0,  32'hC000_8000, 16'h8000, 16'hF000},
      '{1'b0, 6'd1,  32'hFFFF,     16'h0000, 16'hF000}
    };

    reset = 1'b0; s_address = '0; s_write = 1'b0; s_read = 1'b0;
    s_writedata = '0; ext = '0; lamps = '0;
    repeat (3) @(negedge clk);
    chk("rst_keys", 32'(keys), 32'h0);
    chk("rst_sw", 32'(sw), 32'h0);
    chk("rst_ext_db", 32'(ext_db), 32'h0);
    chk("rst_irq", 32'(s_irq), 32'h0);
    chk("rst_rdata", s_readdata, 32'h0);
    chk("rst_wait", 32'(s_waitrequest), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].is_rd) rd(tbl[i].addr, tbl[i].data);
      else              wr(tbl[i].addr, tbl[i].data);
      chk($sformatf("vec%0d_keys", i), 32'(keys), 32'(tbl[i].exp_keys));
      chk($sformatf("vec%0d_sw", i), 32'(sw), 32'(tbl[i].exp_sw));
    end

    pulse_seq(-1, 6'd4, 5);
    pulse_seq(3, 6'd4, 8);
    pulse_seq(2, 6'd1, 2);

    // read+write together: write happens, no wait state
    s_address = 6'd2; s_writedata = 32'h000F; s_write = 1'b1; s_read = 1'b1;
    #1 chk("rdwr_wait", 32'(s_waitrequest), 32'h0);
    @(negedge clk);
    s_write = 1'b0; s_read = 1'b0;
    chk("rdwr_sw", 32'(sw), 32'hF00F);
    $display("rdwr addr=2 data=000f sw=%h", sw);
    wr(6'd3, 32'h000F);
    chk("sw_after_clr", 32'(sw), 32'hF000);

    // lamp snapshot coherence
    lamps = {32'h66, 32'h55, 32'h22, 32'h11};
    rd(6'd9, 32'h0);
    rd(6'd8, 32'h11);
    lamps = {32'h66, 32'h55, 32'h44, 32'h33};
    rd(6'd9, 32'h22);
    rd(6'd11, 32'h66);
    lamps = {32'h77, 32'h55, 32'h44, 32'h33};
    wr(6'd6, 32'h0);
    rd(6'd9, 32'h44);
    rd(6'd11, 32'h77);
    rd(6'd12, 32'h0);

    // debounce: bouncing input never accepted
    for (int c = 0; c < 36; c++) begin
      if (c % 3 == 0) ext[0] = ~ext[0];
      @(negedge clk);
    end
    chk("bounce_ext_db", 32'(ext_db), 32'h0);
    chk("bounce_irq", 32'(s_irq), 32'h0);
    ext = '0;
    repeat (15) @(negedge clk);
    chk("quiet_ext_db", 32'(ext_db), 32'h0);
    ext[0] = 1'b1;
    n = 0;
    while (ext_db[0] == 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("db_latency", 32'(n), 32'd11);
    chk("db_irq_set", 32'(s_irq), 32'h1);
    $display("debounce rise latency=%0d", n);
    rd(6'd5, 32'h8000_0001);
    wr(6'd5, 32'h0);
    chk("irq_cleared", 32'(s_irq), 32'h0);
    rd(6'd5, 32'h0000_0001);

    // falling edge re-raises irq, then reset mid-pulse
    ext[0] = 1'b0;
    n = 0;
    while (ext_db[0] == 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("db_fall_latency", 32'(n), 32'd11);
    chk("db_fall_irq", 32'(s_irq), 32'h1);
    s_address = 6'd4; s_writedata = 32'h4; s_write = 1'b1;
    @(negedge clk);
    s_write = 1'b0;
    chk("pre_rst_key", 32'(keys), 32'h4);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_keys", 32'(keys), 32'h0);
    chk("async_rst_sw", 32'(sw), 32'h0);
    chk("async_rst_irq", 32'(s_irq), 32'h0);
    chk("async_rst_rdata", s_readdata, 32'h0);
    $display("reset asserted mid-pulse");
    @(negedge clk);
    reset = 1'b1;
    lamps = {32'h77, 32'h55, 32'h44, 32'h99};
    repeat (6) @(negedge clk);
    chk("post_rst_keys", 32'(keys), 32'h0);
    rd(6'd9, 32'h0);
    rd(6'd8, 32'h99);
    rd(6'd9, 32'h44);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
